// File: rtl/ud_count_tracker.sv
// Receive-side tracker for a mod-N up/down counter: recovers single steps and wraps,
// accumulates a signed position, and locks out on illegal transitions until cleared.
//
// state       | meaning
// ST_UNLOCKED | waiting for the first in-range sample to seed prev/Position
// ST_LOCKED   | following the counter one legal step at a time
// ST_ERROR    | illegal transition seen; samples ignored until clear_err
module ud_count_tracker #(
  parameter int MODULUS = 12,
  parameter int CW      = 4,
  parameter int POS_W   = 16
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             sample_en,
  input  logic [CW-1:0]    Count_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             step_up,
  output logic             step_down,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic             Direction,
  output logic [POS_W-1:0] Position,
  output logic             error
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MODULUS - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    prev_q, prev_d;
  logic [CW-1:0]    inc_prev, dec_prev;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             up_q, up_d, dn_q, dn_d;
  logic             wu_q, wu_d, wd_q, wd_d;
  logic             in_range;

  always_comb begin
    inc_prev = (prev_q == MAX_CNT) ? '0 : prev_q + 1'b1;
    dec_prev = (prev_q == '0) ? MAX_CNT : prev_q - 1'b1;
    in_range = (Count_in <= MAX_CNT);
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    wu_d    = 1'b0;
    wd_d    = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (sample_en) begin
          if (in_range) begin
            prev_d  = Count_in;
            pos_d   = POS_W'(Count_in);
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_LOCKED: begin
        if (sample_en) begin
          if (!in_range) begin
            state_d = ST_ERROR;
          end else if (Count_in == prev_q) begin
            state_d = ST_LOCKED;
          end else if (Count_in == inc_prev) begin
            up_d   = 1'b1;
            wu_d   = (prev_q == MAX_CNT);
            pos_d  = pos_q + POS_W'(1);
            dir_d  = 1'b1;
            prev_d = Count_in;
          end else if (Count_in == dec_prev) begin
            dn_d   = 1'b1;
            wd_d   = (prev_q == '0);
            pos_d  = pos_q - POS_W'(1);
            dir_d  = 1'b0;
            prev_d = Count_in;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        // clear_err wins over a same-cycle sample; relock needs a fresh sample
        if (clear_err) state_d = ST_UNLOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q <= ST_UNLOCKED;
      prev_q  <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      wu_q    <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      wu_q    <= wu_d;
      wd_q    <= wd_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign error     = (state_q == ST_ERROR);
  assign step_up   = up_q;
  assign step_down = dn_q;
  assign wrap_up   = wu_q;
  assign wrap_down = wd_q;
  assign Direction = dir_q;
  assign Position  = pos_q;

endmodule
